// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP16 adder sharing controller: format width,
// default adder depth and the tag-pipe stage record.
package fpadd_pkg;

  // Operand/result width of the half-precision format
  localparam int FP16_W = 16;

  // Default number of edges from operands on the adder inputs to its sum
  localparam int ADD_LAT_DEFAULT = 4;

  // One tag-pipe stage: is an operation here, and which requester owns it
  typedef struct packed {
    logic valid;
    logic tag;
  } tag_stage_t;

endpackage

// File: rtl/fpadd_resp_fifo.sv
// Synchronous result FIFO for one requester. Exposes its occupancy so the
// issue logic can reserve space before an operation enters the adder.
module fpadd_resp_fifo
  import fpadd_pkg::*;
#(
  parameter int W     = FP16_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees its slot in the same cycle, so a full FIFO may still accept
  // a push when it is also being popped
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The head reads as zero while empty so an idle channel shows a clean bus
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only observable through a valid pointer
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_share_ctrl.sv
// Shares one pipelined FP16 adder between two requesters. A round-robin
// arbiter issues one operand pair per cycle, a tag pipe follows each
// operation through the adder, and per-requester FIFOs hold results until
// their consumer takes them. Issue is credit-gated so no result is dropped.
module fpadd_share_ctrl
  import fpadd_pkg::*;
#(
  parameter int ADD_LAT    = ADD_LAT_DEFAULT,
  parameter int RESP_DEPTH = 4,
  parameter int W          = FP16_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  output logic         r0_rvalid,
  input  logic         r0_rready,
  output logic [W-1:0] r0_result,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic         r1_rvalid,
  input  logic         r1_rready,
  output logic [W-1:0] r1_result,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_c,
  output logic         busy
);

  // Stage 0 sits alongside the registered adder operands and stage ADD_LAT
  // lines up with the matching sum on add_c, so the pipe holds ADD_LAT+1
  // entries in total
  localparam int NSTG = ADD_LAT + 1;
  localparam int CW   = $clog2(RESP_DEPTH + 1);
  localparam int SW   = $clog2(RESP_DEPTH + NSTG + 1);

  tag_stage_t    stg [NSTG];
  tag_stage_t    wb;
  logic          favor1;

  logic [SW-1:0] inflight0;
  logic [SW-1:0] inflight1;
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;
  logic          empty0;
  logic          empty1;
  logic          full0;
  logic          full1;

  logic          elig0;
  logic          elig1;
  logic          grant0;
  logic          grant1;
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;
  logic          any_inflight;

  // Count how many operations each requester has somewhere in the adder
  always_comb begin
    inflight0    = '0;
    inflight1    = '0;
    any_inflight = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      if (stg[i].valid) begin
        any_inflight = 1'b1;
        if (stg[i].tag) begin
          inflight1 = inflight1 + SW'(1);
        end else begin
          inflight0 = inflight0 + SW'(1);
        end
      end
    end
  end

  // A requester may issue only if its FIFO can absorb everything already in
  // flight plus this new operation; pops this cycle are deliberately ignored
  always_comb begin
    elig0  = r0_valid && ((SW'(count0) + inflight0) < SW'(RESP_DEPTH));
    elig1  = r1_valid && ((SW'(count1) + inflight1) < SW'(RESP_DEPTH));
    grant0 = rst && elig0 && (!elig1 || !favor1);
    grant1 = rst && elig1 && (!elig0 ||  favor1);
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Operand registers, tag pipe and round-robin pointer. The pointer only
  // moves under contention, handing priority to the requester that lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_a  <= '0;
      add_b  <= '0;
      favor1 <= 1'b0;
      for (int i = 0; i < NSTG; i++) begin
        stg[i] <= '{valid: 1'b0, tag: 1'b0};
      end
    end else begin
      if (grant0) begin
        add_a <= r0_a;
        add_b <= r0_b;
      end else if (grant1) begin
        add_a <= r1_a;
        add_b <= r1_b;
      end else begin
        add_a <= '0;
        add_b <= '0;
      end
      stg[0] <= '{valid: grant0 || grant1, tag: grant1};
      for (int i = 1; i < NSTG; i++) begin
        stg[i] <= stg[i-1];
      end
      if (elig0 && elig1) begin
        favor1 <= grant0;
      end
    end
  end

  // The last tag stage steers the adder output into its owner's FIFO
  always_comb begin
    wb    = stg[ADD_LAT];
    push0 = wb.valid && !wb.tag;
    push1 = wb.valid &&  wb.tag;
    pop0  = r0_rvalid && r0_rready;
    pop1  = r1_rvalid && r1_rready;
  end

  fpadd_resp_fifo #(
    .W     (W),
    .DEPTH (RESP_DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (add_c),
    .pop       (pop0),
    .head      (r0_result),
    .empty     (empty0),
    .full      (full0),
    .count     (count0)
  );

  fpadd_resp_fifo #(
    .W     (W),
    .DEPTH (RESP_DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (add_c),
    .pop       (pop1),
    .head      (r1_result),
    .empty     (empty1),
    .full      (full1),
    .count     (count1)
  );

  assign r0_rvalid = !empty0;
  assign r1_rvalid = !empty1;

  // Busy whenever anything is still travelling through the adder or queued
  always_comb begin
    busy = any_inflight || !empty0 || !empty1;
  end

`ifndef SYNTHESIS
  // Credit gating must keep every writeback target from overflowing
  always_ff @(posedge clk) begin
    if (rst && push0) begin
      assert (!full0 || pop0);
    end
    if (rst && push1) begin
      assert (!full1 || pop1);
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Directed bench for the shared FP16 adder controller with a reference
// adder pipeline and per-requester result scoreboards.
module tb_fpadd_share_ctrl;

  logic        clk;
  logic        rst;
  logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
  logic [15:0] r0_a, r0_b, r0_result;
  logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
  logic [15:0] r1_a, r1_b, r1_result;
  logic [15:0] add_a, add_b, add_c;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int acc0 = 0, acc1 = 0, del0 = 0, del1 = 0;
  int last0 = 0, last1 = 0;
  int c920_seen = 0;
  logic [15:0] last_res0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] apipe [4];

  fpadd_share_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_rvalid (r0_rvalid),
    .r0_rready (r0_rready),
    .r0_result (r0_result),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_rvalid (r1_rvalid),
    .r1_rready (r1_rready),
    .r1_result (r1_result),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Reference sums for the operand pairs this bench uses
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h5620_5948: return 16'h5C2C;
      32'h5630_D590: return 16'h4900;
      32'hD1A0_54F0: return 16'h5040;
      32'hDC6C_D420: return 16'hDD74;
      32'h0000_D750: return 16'hD750;
      32'h0000_0000: return 16'h0000;
      32'hD6E2_563E: return 16'hC920;
      32'h56EE_5632: return 16'h5A90;
      default:       return a ^ b ^ 16'h1234;
    endcase
  endfunction

  // Four-stage adder model standing in for the shared FP unit
  always @(posedge clk) begin
    apipe[0] <= fp_add(add_a, add_b);
    for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
  end
  assign add_c = apipe[3];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on operand handshake, pop and compare on result handshake
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (r0_valid && r0_ready) begin q0.push_back(fp_add(r0_a, r0_b)); acc0++; end
      if (r1_valid && r1_ready) begin q1.push_back(fp_add(r1_a, r1_b)); acc1++; end
      if (r0_rvalid && r0_rready) begin
        if (r0_result == 16'hC920) c920_seen++;
        if (q0.size() == 0) check_output("r0_spurious", {16'h0, r0_result}, 32'h1_0000);
        else check_output("r0_result", {16'h0, r0_result}, {16'h0, q0.pop_front()});
        del0++; last0 = cycle; last_res0 = r0_result;
      end
      if (r1_rvalid && r1_rready) begin
        if (q1.size() == 0) check_output("r1_spurious", {16'h0, r1_result}, 32'h1_0000);
        else check_output("r1_result", {16'h0, r1_result}, {16'h0, q1.pop_front()});
        del1++; last1 = cycle;
      end
    end
  end

  // Present one operand pair and hold it until accepted (bounded)
  task automatic apply_stimulus(input int who, input logic [15:0] a, input logic [15:0] b);
    logic accepted = 1'b0;
    if (who == 0) begin r0_valid = 1'b1; r0_a = a; r0_b = b; end
    else          begin r1_valid = 1'b1; r1_a = a; r1_b = b; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if ((who == 0) ? r0_ready : r1_ready) begin accepted = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (who == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    check_output("handshake", {31'b0, accepted}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, base_acc, base_del, d1;
    logic found;
    rst = 1'b0;
    r0_valid = 1'b1; r0_a = '0; r0_b = '0; r0_rready = 1'b1;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_rready = 1'b1;
    idle(3);
    check_output("rst_add_a", {16'h0, add_a}, 32'h0);
    check_output("rst_add_b", {16'h0, add_b}, 32'h0);
    check_output("rst_r0_ready", {31'b0, r0_ready}, 32'd0);
    check_output("rst_rvalid", {30'b0, r0_rvalid, r1_rvalid}, 32'd0);
    check_output("rst_results", {r0_result, r1_result}, 32'h0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    r0_valid = 1'b0;
    rst = 1'b1;
    idle(2);

    $display("[TB] r0 only, latency");
    d1 = del1;
    apply_stimulus(0, 16'h5620, 16'h5948);
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (r0_rvalid) begin lat = k; found = 1'b1; break; end
    end
    check_output("t1_latency", lat, 32'd5);
    idle(5);
    check_output("t1_r1_silent", del1 - d1, 32'd0);

    $display("[TB] simultaneous requests");
    r0_valid = 1'b1; r0_a = 16'h5630; r0_b = 16'hD590;
    r1_valid = 1'b1; r1_a = 16'hD1A0; r1_b = 16'h54F0;
    @(negedge clk);
    check_output("t2_first_grant", {30'b0, r0_ready, r1_ready}, 32'b10);
    @(posedge clk); #1; r0_valid = 1'b0;
    @(negedge clk);
    check_output("t2_second_grant", {30'b0, r0_ready, r1_ready}, 32'b01);
    @(posedge clk); #1; r1_valid = 1'b0;
    idle(10);
    check_output("t2_spacing", last1 - last0, 32'd1);

    $display("[TB] back-to-back streams");
    base_acc = acc0; d1 = acc1;
    r0_valid = 1'b1; r0_a = 16'hDC6C; r0_b = 16'hD420;
    r1_valid = 1'b1; r1_a = 16'h0000; r1_b = 16'hD750;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_output("t3_one_grant", {31'b0, r0_ready ^ r1_ready}, 32'd1);
      @(posedge clk); #1;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    check_output("t3_r0_issued", acc0 - base_acc, 32'd4);
    check_output("t3_r1_issued", acc1 - d1, 32'd4);
    idle(12);

    $display("[TB] backpressure");
    base_acc = acc0; base_del = del0;
    r0_rready = 1'b0;
    r0_valid = 1'b1; r0_a = 16'h0000; r0_b = 16'h0000;
    idle(20);
    check_output("t4_accepted", acc0 - base_acc, 32'd4);
    @(negedge clk);
    check_output("t4_ready_low", {31'b0, r0_ready}, 32'd0);
    check_output("t4_rvalid", {31'b0, r0_rvalid}, 32'd1);
    @(posedge clk); #1;
    r0_rready = 1'b1;
    idle(4);
    r0_valid = 1'b0;
    idle(15);
    check_output("t4_resumed", {31'b0, (acc0 - base_acc) > 4}, 32'd1);
    check_output("t4_drained", del0 - base_del, acc0 - base_acc);

    $display("[TB] reset mid-flight");
    base_del = del0;
    apply_stimulus(0, 16'hD6E2, 16'h563E);
    idle(2);
    rst = 1'b0;
    r0_valid = 1'b1;
    #2;
    check_output("t5_ready_in_rst", {31'b0, r0_ready}, 32'd0);
    check_output("t5_busy_in_rst", {31'b0, busy}, 32'd0);
    check_output("t5_rvalid_in_rst", {31'b0, r0_rvalid}, 32'd0);
    check_output("t5_add_a_in_rst", {16'h0, add_a}, 32'h0);
    q0.delete(); q1.delete();
    idle(3);
    r0_valid = 1'b0;
    rst = 1'b1;
    idle(15);
    check_output("t5_no_c920", c920_seen, 32'd0);
    check_output("t5_no_delivery", del0 - base_del, 32'd0);
    apply_stimulus(0, 16'h56EE, 16'h5632);
    idle(10);
    check_output("t5_post_result", {16'h0, last_res0}, 32'h5A90);
    check_output("t5_post_count", del0 - base_del, 32'd1);

    check_output("end_q0_empty", q0.size(), 32'd0);
    check_output("end_q1_empty", q1.size(), 32'd0);
    check_output("end_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
